// File: rtl/game_pkg.sv
// Shared definitions for the side-scroller frame scheduler.
//   state_e    : FSM state encoding (4 bits), one REQ/REL pair per client stage
//   STAGE_*    : externally visible stage codes, 0 idle .. 4 draw
//   DEF_*      : default frame divider, handshake timeout and divider width
//   stage_of() : maps a state onto its stage code
package game_pkg;

  typedef enum logic [3:0] {
    StIdle       = 4'd0,
    StEraseReq   = 4'd1,
    StEraseRel   = 4'd2,
    StCollideReq = 4'd3,
    StCollideRel = 4'd4,
    StMoveReq    = 4'd5,
    StMoveRel    = 4'd6,
    StDrawReq    = 4'd7,
    StDrawRel    = 4'd8
  } state_e;

  localparam logic [2:0] STAGE_IDLE    = 3'd0;
  localparam logic [2:0] STAGE_ERASE   = 3'd1;
  localparam logic [2:0] STAGE_COLLIDE = 3'd2;
  localparam logic [2:0] STAGE_MOVE    = 3'd3;
  localparam logic [2:0] STAGE_DRAW    = 3'd4;

  // 60 Hz frame at 50 MHz.
  localparam int unsigned DEF_FRAME_DIV = 833333;
  localparam int unsigned DEF_TIMEOUT   = 4096;
  localparam int unsigned DEF_CNT_W     = 20;

  function automatic logic [2:0] stage_of(input state_e st);
    logic [2:0] code;
    code = STAGE_IDLE;
    unique case (st)
      StEraseReq,   StEraseRel:   code = STAGE_ERASE;
      StCollideReq, StCollideRel: code = STAGE_COLLIDE;
      StMoveReq,    StMoveRel:    code = STAGE_MOVE;
      StDrawReq,    StDrawRel:    code = STAGE_DRAW;
      default:                    code = STAGE_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/frame_sequencer_timer.sv
// Frame divider: free-running counter 0..FRAME_DIV-1.
//   clock  : system clock
//   resetn : asynchronous active-low reset, counter returns to 0
//   tick_o : one-cycle pulse while the counter sits at FRAME_DIV-1
module frame_timer #(
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned FRAME_DIV = 833333
) (
  input  logic clock,
  input  logic resetn,
  output logic tick_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick_o = (count_q == CNT_W'(FRAME_DIV - 1));

  always_comb begin
    count_d = tick_o ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: on each frame tick runs erase, collide, move and draw clients in order
// with a level enable/done handshake, latches the jump button between frames and forwards it
// as a one-cycle pulse when the movement stage starts.
//   clock, resetn           : system clock, asynchronous active-low reset
//   jump_btn                : raw jump button (asynchronous)
//   <x>_en / <x>_done       : handshake with erase, collide, move and draw clients
//   jump                    : one-cycle pulse on entry to the movement stage
//   busy, stage             : scheduler activity and current stage code (0 idle .. 4 draw)
//   frame_count             : completed frames, wraps at 8 bits
//   overrun, timeout_err    : sticky error flags, cleared only by reset
module frame_sequencer
  import game_pkg::*;
#(
  parameter int unsigned FRAME_DIV = DEF_FRAME_DIV,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       jump_btn,
  output logic       erase_en,
  input  logic       erase_done,
  output logic       collide_en,
  input  logic       collide_done,
  output logic       move_en,
  input  logic       move_done,
  output logic       draw_en,
  input  logic       draw_done,
  output logic       jump,
  output logic       busy,
  output logic [2:0] stage,
  output logic [7:0] frame_count,
  output logic       overrun,
  output logic       timeout_err
);

  localparam int unsigned PH_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [3:0]      en_q, en_d;          // bit order: erase, collide, move, draw
  logic            jump_meta_q, jump_sync_q, jump_prev_q;
  logic            jump_latch_q, jump_latch_d;
  logic            jump_q, jump_d;
  logic [7:0]      frame_count_q, frame_count_d;
  logic            overrun_q, overrun_d;
  logic            timeout_err_q, timeout_err_d;

  logic tick;
  logic timed_out;
  logic move_entry;
  logic jump_rise;
  logic frame_done;

  frame_timer #(
    .CNT_W     (CNT_W),
    .FRAME_DIV (FRAME_DIV)
  ) u_timer (
    .clock  (clock),
    .resetn (resetn),
    .tick_o (tick)
  );

  assign timed_out = (state_q != StIdle) && (phase_q == PH_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a timeout aborts the frame from any handshake phase.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:       if (tick)          state_d = StEraseReq;
      StEraseReq:   if (erase_done)    state_d = StEraseRel;
      StEraseRel:   if (!erase_done)   state_d = StCollideReq;
      StCollideReq: if (collide_done)  state_d = StCollideRel;
      StCollideRel: if (!collide_done) state_d = StMoveReq;
      StMoveReq:    if (move_done)     state_d = StMoveRel;
      StMoveRel:    if (!move_done)    state_d = StDrawReq;
      StDrawReq:    if (draw_done)     state_d = StDrawRel;
      StDrawRel:    if (!draw_done)    state_d = StIdle;
      default:                         state_d = StIdle;
    endcase
    if (timed_out) begin
      state_d = StIdle;
    end
  end

  // Output and datapath next-state logic.
  always_comb begin
    // Enable stays high only while the REQ state persists, so it rises one cycle after entry
    // and drops on the same edge that leaves the REQ state.
    en_d = '0;
    unique case (state_q)
      StEraseReq:   en_d[0] = (state_d == state_q);
      StCollideReq: en_d[1] = (state_d == state_q);
      StMoveReq:    en_d[2] = (state_d == state_q);
      StDrawReq:    en_d[3] = (state_d == state_q);
      default:      en_d    = '0;
    endcase

    if ((state_d != state_q) || (state_q == StIdle)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PH_W'(1);
    end

    move_entry = (state_d == StMoveReq) && (state_q != StMoveReq);
    jump_rise  = jump_sync_q & ~jump_prev_q;
    jump_d     = move_entry & jump_latch_q;
    // A fresh edge beats the clear so a press landing on the hand-off is not lost.
    if (jump_rise) begin
      jump_latch_d = 1'b1;
    end else if (move_entry) begin
      jump_latch_d = 1'b0;
    end else begin
      jump_latch_d = jump_latch_q;
    end

    frame_done    = (state_q == StDrawRel) && (state_d == StIdle) && !timed_out;
    frame_count_d = frame_done ? frame_count_q + 8'd1 : frame_count_q;
    overrun_d     = overrun_q | (tick & (state_q != StIdle));
    timeout_err_d = timeout_err_q | timed_out;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase_q       <= '0;
      en_q          <= '0;
      jump_meta_q   <= 1'b0;
      jump_sync_q   <= 1'b0;
      jump_prev_q   <= 1'b0;
      jump_latch_q  <= 1'b0;
      jump_q        <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      en_q          <= en_d;
      jump_meta_q   <= jump_btn;
      jump_sync_q   <= jump_meta_q;
      jump_prev_q   <= jump_sync_q;
      jump_latch_q  <= jump_latch_d;
      jump_q        <= jump_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign erase_en    = en_q[0];
  assign collide_en  = en_q[1];
  assign move_en     = en_q[2];
  assign draw_en     = en_q[3];
  assign jump        = jump_q;
  assign busy        = (state_q != StIdle);
  assign stage       = stage_of(state_q);
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer. Main instance: FRAME_DIV=100, TIMEOUT=16, driven frame by frame
// with randomised client delays, stuck/never-done clients and jump presses. A second instance
// with TIMEOUT=256 and a slow draw client exercises the overrun path.
module tb_frame_sequencer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       jump_btn;
  logic [7:0] en_w;
  logic [7:0] done_r;

  logic       jump, busy, overrun, timeout_err;
  logic [2:0] stage;
  logic [7:0] frame_count;
  logic       jump_b, busy_b, overrun_b, timeout_err_b;
  logic [2:0] stage_b;
  logic [7:0] frame_count_b;

  always #5 clock = ~clock;

  frame_sequencer #(.FRAME_DIV(100), .TIMEOUT(16), .CNT_W(7)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .jump_btn     (jump_btn),
    .erase_en     (en_w[0]),
    .erase_done   (done_r[0]),
    .collide_en   (en_w[1]),
    .collide_done (done_r[1]),
    .move_en      (en_w[2]),
    .move_done    (done_r[2]),
    .draw_en      (en_w[3]),
    .draw_done    (done_r[3]),
    .jump         (jump),
    .busy         (busy),
    .stage        (stage),
    .frame_count  (frame_count),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  frame_sequencer #(.FRAME_DIV(100), .TIMEOUT(256), .CNT_W(7)) dut_ov (
    .clock        (clock),
    .resetn       (resetn),
    .jump_btn     (1'b0),
    .erase_en     (en_w[4]),
    .erase_done   (done_r[4]),
    .collide_en   (en_w[5]),
    .collide_done (done_r[5]),
    .move_en      (en_w[6]),
    .move_done    (done_r[6]),
    .draw_en      (en_w[7]),
    .draw_done    (done_r[7]),
    .jump         (jump_b),
    .busy         (busy_b),
    .stage        (stage_b),
    .frame_count  (frame_count_b),
    .overrun      (overrun_b),
    .timeout_err  (timeout_err_b)
  );

  // Client models: done rises req_dly cycles after en is seen, falls rel_dly cycles after en
  // drops unless stuck.
  int req_dly [8];
  int rel_dly [8];
  bit stuck   [8];
  int ccnt    [8];

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        done_r[i] <= 1'b0;
        ccnt[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (en_w[i]) begin
          if (!done_r[i]) begin
            if (ccnt[i] >= req_dly[i]) begin
              done_r[i] <= 1'b1;
              ccnt[i]   <= 0;
            end else begin
              ccnt[i] <= ccnt[i] + 1;
            end
          end else begin
            ccnt[i] <= 0;
          end
        end else if (done_r[i] && !stuck[i]) begin
          if (ccnt[i] >= rel_dly[i]) begin
            done_r[i] <= 1'b0;
            ccnt[i]   <= 0;
          end else begin
            ccnt[i] <= ccnt[i] + 1;
          end
        end else begin
          ccnt[i] <= 0;
        end
      end
    end
  end

  // Clock edges since reset release; equals the divider count modulo 100.
  int ecount;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) ecount <= 0;
    else         ecount <= ecount + 1;
  end

  int total = 0;
  int bad   = 0;

  // Event kinds: 1..4 enable rise of erase/collide/move/draw, 5 jump, 6 frame completed (val).
  typedef struct {
    int kind;
    int val;
  } ev_t;
  ev_t exp_q[$];

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got kind=%0d val=%0d want none", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        bad++;
        $display("FAIL event_order got kind=%0d val=%0d want kind=%0d val=%0d",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: turns DUT activity into events and compares against the scoreboard queue.
  initial begin
    logic [3:0] en_prev;
    logic [7:0] fc_prev;
    en_prev = '0;
    fc_prev = '0;
    forever begin
      @(negedge clock);
      if (resetn === 1'b1) begin
        total++;
        if ($countones(en_w[3:0]) > 1) begin
          bad++;
          $display("FAIL en_overlap got=%b want at most one high", en_w[3:0]);
        end
        if (jump === 1'b1) observe(5, 0);
        for (int i = 0; i < 4; i++) begin
          if (en_w[i] && !en_prev[i]) observe(i + 1, 0);
        end
        if (frame_count != fc_prev) observe(6, int'(frame_count));
      end
      en_prev = en_w[3:0];
      fc_prev = frame_count;
    end
  end

  task automatic wait_ecount(input int n);
    while (ecount < n) @(negedge clock);
  endtask

  // Reference state at frame granularity.
  int fc_m     = 0;
  bit terr_m   = 0;
  bit latch_m  = 0;

  task automatic idle_check();
    check("idle_busy", busy, 0);
    check("idle_stage", stage, 0);
    check("idle_en", en_w[3:0], 0);
    check("idle_jump", jump, 0);
    check("frame_count", frame_count, fc_m);
    check("timeout_err", timeout_err, terr_m);
    check("overrun", overrun, 0);
  endtask

  // kind 0: normal; 1: client s never answers; 2: client s holds done after its handshake.
  task automatic plan(input int p, input int kind, input int s, input bit press,
                      input bit instant);
    int last;
    for (int i = 0; i < 4; i++) begin
      req_dly[i] = instant ? 0 : $urandom_range(0, 5);
      rel_dly[i] = instant ? 0 : $urandom_range(0, 5);
      stuck[i]   = 1'b0;
    end
    if (kind == 1) req_dly[s-1] = 100;
    if (kind == 2) stuck[s-1] = 1'b1;
    if (press) latch_m = 1'b1;
    last = (kind == 0) ? 4 : s;
    for (int st = 1; st <= last; st++) begin
      if (st == 3) begin
        if (latch_m) push(5, 0);
        latch_m = 1'b0;
      end
      push(st, 0);
    end
    if (kind == 0) begin
      fc_m = (fc_m + 1) % 256;
      push(6, fc_m);
    end else begin
      terr_m = 1'b1;
    end
    if (press) begin
      wait_ecount(100 * p - 12);
      jump_btn = 1'b1;
      wait_ecount(100 * p - 8);
      jump_btn = 1'b0;
    end
  endtask

  // Overrun instance: draw takes ~123 cycles, so the tick at count 199 lands mid-frame.
  initial begin
    @(posedge resetn);
    wait_ecount(150);
    check("ov_busy_150", busy_b, 1);
    check("ov_stage_150", stage_b, 4);
    check("ov_overrun_150", overrun_b, 0);
    check("ov_fc_150", frame_count_b, 0);
    wait_ecount(250);
    check("ov_overrun_250", overrun_b, 1);
    check("ov_fc_250", frame_count_b, 1);
    check("ov_busy_250", busy_b, 0);
    check("ov_terr_250", timeout_err_b, 0);
    wait_ecount(350);
    check("ov_busy_350", busy_b, 1);
    check("ov_fc_350", frame_count_b, 1);
  end

  localparam int NF = 28;

  initial begin
    int kinds  [8] = '{0, 0, 0, 0, 1, 0, 2, 0};
    int stages [8] = '{0, 0, 0, 0, 2, 0, 3, 0};
    bit presses[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    bit inst   [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    int prev_kind;
    int kind, s, r;
    bit press;

    resetn   = 1'b0;
    jump_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_dly[i] = 0;
      rel_dly[i] = 0;
      stuck[i]   = 1'b0;
    end
    req_dly[7] = 120;
    repeat (3) @(negedge clock);
    #2;
    check("rst_en", en_w[3:0], 0);
    check("rst_stage", stage, 0);
    check("rst_busy", busy, 0);
    check("rst_fc", frame_count, 0);
    resetn = 1'b1;
    #1;
    check("rel_jump", jump, 0);
    check("rel_overrun", overrun, 0);
    check("rel_terr", timeout_err, 0);

    prev_kind = 0;
    for (int p = 1; p <= NF; p++) begin
      wait_ecount(100 * p - 15);
      idle_check();
      if (p <= 8) begin
        kind  = kinds[p-1];
        s     = stages[p-1];
        press = presses[p-1];
        plan(p, kind, s, press, inst[p-1]);
      end else begin
        r     = $urandom_range(0, 9);
        kind  = (prev_kind == 2) ? 0 : (r < 6) ? 0 : (r < 8) ? 1 : 2;
        s     = $urandom_range(1, 4);
        press = ($urandom_range(0, 2) == 0);
        plan(p, kind, s, press, 1'b0);
      end
      prev_kind = kind;
    end
    wait_ecount(100 * (NF + 1) - 15);
    idle_check();
    check("scoreboard_drained", exp_q.size(), 0);

    // Reset while the collision client is being requested.
    for (int i = 0; i < 4; i++) begin
      req_dly[i] = 0;
      rel_dly[i] = 0;
      stuck[i]   = 1'b0;
    end
    req_dly[1] = 5;
    push(1, 0);
    push(2, 0);
    for (int k = 0; k < 300 && !en_w[1]; k++) @(negedge clock);
    check("collide_en_seen", en_w[1], 1);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_en", en_w[3:0], 0);
    check("midrst_stage", stage, 0);
    check("midrst_busy", busy, 0);
    check("midrst_fc", frame_count, 0);
    check("midrst_terr", timeout_err, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_jump", jump, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
